// File: rtl/sram_dp_banked.sv
// Dual-port, word-interleaved banked SRAM with round-robin arbitration on bank conflicts.
// Define SRAM_CONFLICT_CNT_EN to build the saturating bank-conflict counter.
module sram_dp_banked #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_WORDS  = 1024,
   parameter int unsigned NUM_BANKS  = 2,
   parameter int unsigned OUT_REGS   = 0,
   localparam int unsigned AW = $clog2(NUM_WORDS),
   localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  a_req_i,
   output logic                  a_gnt_o,
   input  logic                  a_we_i,
   input  logic [AW-1:0]         a_addr_i,
   input  logic [DATA_WIDTH-1:0] a_wdata_i,
   input  logic [BW-1:0]         a_be_i,
   output logic                  a_rvalid_o,
   output logic [DATA_WIDTH-1:0] a_rdata_o,
   input  logic                  b_req_i,
   output logic                  b_gnt_o,
   input  logic                  b_we_i,
   input  logic [AW-1:0]         b_addr_i,
   input  logic [DATA_WIDTH-1:0] b_wdata_i,
   input  logic [BW-1:0]         b_be_i,
   output logic                  b_rvalid_o,
   output logic [DATA_WIDTH-1:0] b_rdata_o,
   output logic [31:0]           conflict_cnt_o
);

   localparam int unsigned LOG_BANKS = $clog2(NUM_BANKS);
   localparam int unsigned BANK_W    = (LOG_BANKS > 0) ? LOG_BANKS : 1;
   localparam int unsigned ROWS      = NUM_WORDS / NUM_BANKS;
   localparam int unsigned RW        = (AW > LOG_BANKS) ? AW - LOG_BANKS : 1;

   // Index 0 is port A, index 1 is port B.
   logic [1:0]            w_req;
   logic [1:0]            w_we;
   logic [1:0]            w_gnt;
   logic [1:0]            w_rvalid;
   logic [AW-1:0]         w_addr       [2];
   logic [DATA_WIDTH-1:0] w_wdata      [2];
   logic [BW-1:0]         w_be         [2];
   logic [BANK_W-1:0]     w_bank       [2];
   logic [RW-1:0]         w_row        [2];
   logic [DATA_WIDTH-1:0] w_rdata      [2];
   logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];
   logic                  w_conflict;
   logic                  r_rr;
   logic [1:0]            r_rd;
   logic [BANK_W-1:0]     r_rd_bank    [2];

   assign w_req      = {b_req_i, a_req_i};
   assign w_we       = {b_we_i, a_we_i};
   assign w_addr[0]  = a_addr_i;
   assign w_addr[1]  = b_addr_i;
   assign w_wdata[0] = a_wdata_i;
   assign w_wdata[1] = b_wdata_i;
   assign w_be[0]    = a_be_i;
   assign w_be[1]    = b_be_i;

   for (genvar p = 0; p < 2; p++) begin : g_port
      if (LOG_BANKS > 0) begin : g_sel
         assign w_bank[p] = w_addr[p][LOG_BANKS-1:0];
      end else begin : g_nosel
         assign w_bank[p] = '0;
      end
      assign w_row[p]   = RW'(w_addr[p] >> LOG_BANKS);
      assign w_rdata[p] = w_bank_rdata[r_rd_bank[p]];
   end

   assign w_conflict = w_req[0] & w_req[1] & (w_bank[0] == w_bank[1]) & ~rst_i;
   assign w_gnt[0]   = w_req[0] & ~rst_i & (~w_conflict | ~r_rr);
   assign w_gnt[1]   = w_req[1] & ~rst_i & (~w_conflict | r_rr);
   assign a_gnt_o    = w_gnt[0];
   assign b_gnt_o    = w_gnt[1];

   // After a conflict the pointer moves to the loser; untouched otherwise.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr <= 1'b0;
      end else if (w_conflict) begin
         r_rr <= ~r_rr;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] r_mem [ROWS];
      logic [DATA_WIDTH-1:0] r_rdata;
      logic [DATA_WIDTH-1:0] w_mask;
      logic [BW-1:0]         w_be_sel;
      logic                  w_hit_a;
      logic                  w_hit_b;
      logic                  w_sel;

      assign w_hit_a  = w_gnt[0] & (w_bank[0] == BANK_W'(b));
      assign w_hit_b  = w_gnt[1] & (w_bank[1] == BANK_W'(b));
      // Arbitration leaves at most one hit per bank, so the hit alone picks the owner.
      assign w_sel    = w_hit_b;
      assign w_be_sel = w_be[w_sel];

      for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_mask
         assign w_mask[k] = w_be_sel[k/8];
      end

      always_ff @(posedge clk_i) begin
         if (w_hit_a | w_hit_b) begin
            if (w_we[w_sel]) begin
               r_mem[w_row[w_sel]] <= (r_mem[w_row[w_sel]] & ~w_mask) | (w_wdata[w_sel] & w_mask);
            end else begin
               r_rdata <= r_mem[w_row[w_sel]];
            end
         end
      end

      assign w_bank_rdata[b] = r_rdata;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd <= '0;
      end else begin
         r_rd <= w_gnt & ~w_we;
      end
   end

   always_ff @(posedge clk_i) begin
      r_rd_bank[0] <= w_bank[0];
      r_rd_bank[1] <= w_bank[1];
   end

   if (OUT_REGS == 0) begin : g_direct
      logic [DATA_WIDTH-1:0] r_hold [2];

      // Gating with rst_i drops a response that would land in a reset cycle.
      assign w_rvalid = r_rd & {2{~rst_i}};

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_hold[0] <= '0;
            r_hold[1] <= '0;
         end else begin
            for (int p = 0; p < 2; p++) begin
               if (w_rvalid[p]) begin
                  r_hold[p] <= w_rdata[p];
               end
            end
         end
      end

      assign a_rdata_o = w_rvalid[0] ? w_rdata[0] : r_hold[0];
      assign b_rdata_o = w_rvalid[1] ? w_rdata[1] : r_hold[1];
   end else begin : g_outreg
      logic [1:0]            r_vld;
      logic [DATA_WIDTH-1:0] r_dout [2];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_vld     <= '0;
            r_dout[0] <= '0;
            r_dout[1] <= '0;
         end else begin
            r_vld <= r_rd;
            for (int p = 0; p < 2; p++) begin
               if (r_rd[p]) begin
                  r_dout[p] <= w_rdata[p];
               end
            end
         end
      end

      assign w_rvalid  = r_vld & {2{~rst_i}};
      assign a_rdata_o = r_dout[0];
      assign b_rdata_o = r_dout[1];
   end

   assign a_rvalid_o = w_rvalid[0];
   assign b_rvalid_o = w_rvalid[1];

`ifdef SRAM_CONFLICT_CNT_EN
   logic [31:0] r_conflict_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_conflict_cnt <= '0;
      end else if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
   end

   assign conflict_cnt_o = r_conflict_cnt;
`else
   assign conflict_cnt_o = '0;
`endif

endmodule
